// File: rtl/console_writer.sv
// Text-buffer write engine: turns a character stream into text RAM writes,
// tracking the cursor and scrolling by rotating the displayed row offset.
module console_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  charIn,
    input  logic        charValid,
    output logic        charReady,
    output logic [15:0] memAddr,
    output logic [7:0]  memData,
    output logic        memWrite,
    output logic [6:0]  cursorCol,
    output logic [4:0]  cursorRow,
    output logic [4:0]  scrollRow
);

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    localparam logic [16:0] TOTAL    = 17'(COLS * ROWS);
    localparam logic [16:0] LINE     = 17'(COLS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0]  SPACE    = 8'h20;

    logic [1:0]  state;
    logic [16:0] count;
    logic [15:0] clearBase;

    logic [5:0]  rowSum;
    logic [4:0]  physRow;
    logic [15:0] lineBase;
    logic [4:0]  nextScroll;

    logic        doWrite;
    logic [7:0]  writeData;
    logic [6:0]  writeCol;
    logic [6:0]  newCol;
    logic        doNewline;

    // Both operands are below ROWS, so one conditional subtract is the modulo.
    always_comb begin
        rowSum     = {1'b0, scrollRow} + {1'b0, cursorRow};
        physRow    = (rowSum >= 6'(ROWS)) ? 5'(rowSum - 6'(ROWS)) : rowSum[4:0];
        lineBase   = 16'(physRow) * 16'(COLS);
        nextScroll = (scrollRow == LAST_ROW) ? 5'd0 : scrollRow + 5'd1;
    end

    always_comb begin
        doWrite   = 1'b0;
        writeData = charIn;
        writeCol  = cursorCol;
        newCol    = cursorCol;
        doNewline = 1'b0;
        if (charIn >= 8'h20 && charIn <= 8'h7E) begin
            doWrite = 1'b1;
            if (cursorCol == LAST_COL) begin
                newCol    = 7'd0;
                doNewline = 1'b1;
            end else begin
                newCol = cursorCol + 7'd1;
            end
        end else if (charIn == 8'h0A) begin
            newCol    = 7'd0;
            doNewline = 1'b1;
        end else if (charIn == 8'h0D) begin
            newCol = 7'd0;
        end else if (charIn == 8'h08 && cursorCol != 7'd0) begin
            doWrite   = 1'b1;
            writeData = SPACE;
            writeCol  = cursorCol - 7'd1;
            newCol    = cursorCol - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            count     <= '0;
            clearBase <= '0;
            charReady <= 1'b0;
            memWrite  <= 1'b0;
            memAddr   <= '0;
            memData   <= SPACE;
            cursorCol <= '0;
            cursorRow <= '0;
            scrollRow <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (count < TOTAL) begin
                        memWrite <= 1'b1;
                        memAddr  <= count[15:0];
                        memData  <= SPACE;
                        count    <= count + 17'd1;
                    end else begin
                        memWrite  <= 1'b0;
                        charReady <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (charValid && charReady) begin
                        charReady <= 1'b0;
                        memWrite  <= doWrite;
                        if (doWrite) begin
                            memAddr <= lineBase + 16'(writeCol);
                            memData <= writeData;
                        end
                        cursorCol <= newCol;
                        state     <= EXEC;
                        if (doNewline) begin
                            if (cursorRow == LAST_ROW) begin
                                // The old top row becomes the new bottom line.
                                scrollRow <= nextScroll;
                                clearBase <= 16'(scrollRow) * 16'(COLS);
                                count     <= '0;
                                state     <= CLEAR;
                            end else begin
                                cursorRow <= cursorRow + 5'd1;
                            end
                        end
                    end
                end
                EXEC: begin
                    memWrite  <= 1'b0;
                    charReady <= 1'b1;
                    state     <= IDLE;
                end
                CLEAR: begin
                    if (count < LINE) begin
                        memWrite <= 1'b1;
                        memAddr  <= clearBase + count[15:0];
                        memData  <= SPACE;
                        count    <= count + 17'd1;
                    end else begin
                        memWrite  <= 1'b0;
                        charReady <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: doc/console_writer.md
# console_writer

Text-buffer write engine for the console path. Accepts a byte stream of characters over a valid/ready handshake and writes them into the write port of the dual-port text RAM that `ConsoleDriver` reads for display. It tracks the cursor, interprets CR/LF/BS, and scrolls by rotating a row offset (`scrollRow`) and blanking the new bottom line. `ConsoleDriver` adds `scrollRow` to its row index modulo `ROWS` when forming its read address.

## Interface

Parameters:
- `COLS`, default 80: characters per line. Range ≤128.
- `ROWS`, default 30: lines per screen. Range ≤32.
- Constraint: `COLS*ROWS` ≤ 65536.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `charIn` input 8: character byte.
- `charValid` input 1: `charIn` is valid.
- `charReady` output 1: the block accepts `charIn` this cycle.
- `memAddr` output 16: text RAM write address, equal to `physRow*COLS + col`.
- `memData` output 8: text RAM write data.
- `memWrite` output 1: text RAM write enable, one write per cycle.
- `cursorCol` output 7: logical cursor column.
- `cursorRow` output 5: logical cursor row on screen.
- `scrollRow` output 5: physical RAM row currently shown as screen row 0.

## Operation

- Registered outputs. Reset values:
  - `charReady`=0, `memWrite`=0, `memAddr`=0, `memData`=0x20.
  - `cursorCol`=0, `cursorRow`=0, `scrollRow`=0.
- Physical row: `physRow = (scrollRow + cursorRow) mod ROWS`.
- States:
  - INIT
    - Entered from reset.
    - Writes 0x20 to addresses 0 … `COLS*ROWS-1` in ascending order, one per cycle.
    - Then goes to IDLE.
  - IDLE
    - `charReady`=1.
    - Acceptance occurs when `charValid && charReady`. Next state is EXEC.
  - EXEC (1 cycle, `charReady`=0). Behaviour depends on the accepted byte:
    - 0x20–0x7E: write the byte at (`physRow`, `cursorCol`). If `cursorCol`==`COLS-1`: set col to 0 and perform newline. Otherwise increment col.
    - 0x0A (LF): set col to 0 and perform newline.
    - 0x0D (CR): set col to 0. No write.
    - 0x08 (BS): if col>0, decrement col and write 0x20 at the new col. If col==0, no write and no change.
    - Any other byte: accepted and discarded. No write, no cursor change.
  - Newline:
    - If `cursorRow`<`ROWS-1`: increment row and return to IDLE.
    - Otherwise: `cursorRow` stays at `ROWS-1`. `scrollRow` becomes `(scrollRow+1) mod ROWS`. Go to CLEAR with target physical row = old `scrollRow`.
  - CLEAR
    - Writes 0x20 to `target*COLS` … `target*COLS+COLS-1` in ascending order, one per cycle.
    - Then returns to IDLE.
- `memData`/`memAddr` are don't-care when `memWrite`=0. They hold their last values.
- `rst` in any state aborts the operation and restarts INIT. Any partial clear is abandoned.

## Timing

- Reset:
  - `rst` is sampled high at edge R.
  - INIT writes are issued on cycles R+1 … R+`COLS*ROWS`.
  - `charReady` is first 1 in cycle R+`COLS*ROWS`+1.
- Acceptance at cycle T:
  - If the character produces a write, `memWrite`=1 in T+1 with that write's address and data.
  - Cursor outputs take their new values in T+1.
  - `charReady` returns high at T+2 when no scroll occurs.
- With scroll:
  - `scrollRow` updates in T+1.
  - CLEAR writes occur in T+2 … T+`COLS`+1.
  - `charReady` returns high at T+`COLS`+2.
- Maximum throughput: one character per 2 cycles.
- `charIn` is sampled only on the acceptance cycle.
- `charValid` may be held high across non-ready cycles without side effect.

## Test plan

1. Reset with default parameters:
   - Stimulus: pulse `rst`.
   - Required: 2400 consecutive writes, addresses 0 … 2399, data 0x20.
   - `charReady` rises exactly 2401 cycles after the reset edge.
   - All cursor and scroll outputs read 0.
2. Character write after init:
   - Stimulus: send 0x41.
   - Required: in the next cycle, `memWrite`=1, `memAddr`=0, `memData`=0x41, `cursorCol`=1.
   - Then send 0x0D: no write, `cursorCol`=0.
3. Line wrap:
   - Stimulus: send 80 × 0x42 from (0,0).
   - Required: last write at `memAddr`=79, after which cursor = (col 0, row 1).
   - Stimulus: send 0x07.
   - Required: accepted, no write, cursor unchanged.
4. Backspace:
   - Stimulus: cursor at col 5, row 2, send 0x08.
   - Required: write 0x20 at `memAddr`=164, `cursorCol`=4.
   - Stimulus: at col 0, send 0x08.
   - Required: no write, cursor unchanged.
5. Scroll:
   - Stimulus: at row 29 with `scrollRow`=0, send 0x0A.
   - Required: `scrollRow`=1 and 80 writes of 0x20 to addresses 0 … 79; `charReady` is high again 82 cycles after acceptance.
   - Stimulus: send 0x43.
   - Required: write at `memAddr`=0 (`physRow` 0), `cursorRow`=29.
   - Stimulus: scroll 29 more times.
   - Required: `scrollRow` wraps from 29 to 0.
6. Mid-clear reset:
   - Stimulus: assert `rst` during CLEAR.
   - Required: in the next cycle, `scrollRow`=0 and `charReady`=0; a full INIT sequence follows starting at address 0.
